// File: rtl/alu_packet_assembler_pkg.sv
// Shared types and constants for the ALU packet assembler: FSM state encoding,
// recognised opcodes and header/word geometry.
package alu_packet_assembler_pkg;

   typedef enum logic [2:0] {
      ST_OPC,
      ST_RSV,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_COLLECT,
      ST_DROP,
      ST_ISSUE,
      ST_SETTLE
   } asm_state_e;

   localparam logic [7:0] OP_ECHO    = 8'hEC;
   localparam logic [7:0] OP_ADD     = 8'hAD;
   localparam int         HDR_BYTES  = 4;
   localparam int         WORD_BYTES = 4;

   function automatic logic is_known_op(input logic [7:0] op);
      return (op == OP_ECHO) || (op == OP_ADD);
   endfunction

endpackage

// File: rtl/alu_packet_assembler_word_packer.sv
// Little-endian byte-to-word packer. word_o/fill_o/complete_o already include the
// byte presented this cycle, so the owner can capture a finished word on the same edge.
module word_packer
   import alu_packet_assembler_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic [1:0]  fill_o,
   output logic        complete_o
);

   logic [31:0] word_q;
   logic [2:0]  fill_q;
   logic [2:0]  fill_d;

   always_comb begin
      word_o = word_q;
      fill_d = fill_q;
      if (accept_i) begin
         word_o = word_q | ({24'd0, byte_i} << {fill_q[1:0], 3'b000});
         fill_d = fill_q + 3'd1;
      end
   end

   assign fill_o     = fill_d[1:0];
   assign complete_o = (fill_d == 3'(WORD_BYTES));

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         word_q <= '0;
         fill_q <= '0;
      end else begin
         word_q <= word_o;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/alu_packet_assembler.sv
// Parses UART packets (opcode, reserved, 16-bit LE length) and issues payload words to the ALU.
// Optional idle timeout is enabled by defining ALU_ASM_TIMEOUT_EN.
module alu_packet_assembler
   import alu_packet_assembler_pkg::*;
#(
   parameter int                LEN_W          = 16,
   parameter logic [LEN_W-1:0]  MAX_LEN        = LEN_W'(1024),
   parameter logic [31:0]       TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   input  logic        alu_busy_i,
   output logic [7:0]  opcode_o,
   output logic [32:0] data1_o,
   output logic        data1_valid_o,
   output logic [32:0] data2_o,
   output logic        data2_valid_o,
   output logic [1:0]  top_byte_o,
   output logic        start_alu_o,
   output logic        pkt_done_o,
   output logic        err_o
);

   localparam logic [LEN_W-1:0] HDR_LEN = LEN_W'(HDR_BYTES);

   asm_state_e       state_q;
   logic [7:0]       opcode_q;
   logic [7:0]       len_lo_q;
   logic [LEN_W-1:0] remaining_q;
   logic [31:0]      data1_q;
   logic [31:0]      data2_q;
   logic             data1_valid_q;
   logic             data2_valid_q;
   logic             second_word_q;
   logic [1:0]       top_byte_q;
   logic             done_q;
   logic             err_q;

   logic             accept;
   logic             last_byte;
   logic             word_end;
   logic             timeout;
   logic [LEN_W-1:0] len_raw;
   logic [LEN_W-1:0] len_clamped;
   logic             pk_accept;
   logic             pk_clear;
   logic [31:0]      pk_word;
   logic [1:0]       pk_fill;
   logic             pk_complete;

   assign rx_ready_o = !rst && (state_q inside {ST_OPC, ST_RSV, ST_LEN_LO, ST_LEN_HI,
                                                ST_COLLECT, ST_DROP});
   assign start_alu_o = !rst && (state_q == ST_ISSUE) && !alu_busy_i;
   assign accept      = rx_valid_i && rx_ready_o;

   assign len_raw     = LEN_W'({rx_data_i, len_lo_q});
   assign len_clamped = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
   assign last_byte   = (remaining_q == LEN_W'(1));
   assign pk_accept   = accept && (state_q == ST_COLLECT);
   assign word_end    = pk_complete || last_byte;
   assign pk_clear    = (pk_accept && word_end) || timeout ||
                        (accept && (state_q == ST_LEN_HI));

   word_packer u_word_packer (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (pk_clear),
      .accept_i   (pk_accept),
      .byte_i     (rx_data_i),
      .word_o     (pk_word),
      .fill_o     (pk_fill),
      .complete_o (pk_complete)
   );

`ifdef ALU_ASM_TIMEOUT_EN
   logic [31:0] idle_q;
   logic        counting;

   assign counting = state_q inside {ST_RSV, ST_LEN_LO, ST_LEN_HI, ST_COLLECT, ST_DROP};
   assign timeout  = counting && !accept && (idle_q >= TIMEOUT_CYCLES - 32'd1);

   always_ff @(posedge clk) begin
      if (rst || accept || !counting || timeout) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_q + 32'd1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   // Packet FSM; data/valid/top_byte registers only change while collecting, so they
   // hold steady from the start strobe until the next group begins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_OPC;
         opcode_q      <= '0;
         len_lo_q      <= '0;
         remaining_q   <= '0;
         data1_q       <= '0;
         data2_q       <= '0;
         data1_valid_q <= 1'b0;
         data2_valid_q <= 1'b0;
         second_word_q <= 1'b0;
         top_byte_q    <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (timeout) begin
            err_q         <= 1'b1;
            second_word_q <= 1'b0;
            state_q       <= ST_OPC;
         end else begin
            unique case (state_q)
               ST_OPC: if (accept) begin
                  opcode_q <= rx_data_i;
                  state_q  <= ST_RSV;
               end
               ST_RSV: if (accept) state_q <= ST_LEN_LO;
               ST_LEN_LO: if (accept) begin
                  len_lo_q <= rx_data_i;
                  state_q  <= ST_LEN_HI;
               end
               ST_LEN_HI: if (accept) begin
                  second_word_q <= 1'b0;
                  if (len_raw < HDR_LEN) begin
                     err_q   <= 1'b1;
                     state_q <= ST_OPC;
                  end else begin
                     if (len_raw > MAX_LEN) err_q <= 1'b1;
                     remaining_q <= len_clamped - HDR_LEN;
                     if (len_clamped == HDR_LEN) begin
                        done_q  <= 1'b1;
                        state_q <= ST_OPC;
                     end else if (!is_known_op(opcode_q)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DROP;
                     end else begin
                        state_q <= ST_COLLECT;
                     end
                  end
               end
               ST_COLLECT: if (accept) begin
                  remaining_q <= remaining_q - LEN_W'(1);
                  if (!second_word_q) begin
                     data1_valid_q <= 1'b0;
                     data2_valid_q <= 1'b0;
                  end
                  if (word_end) begin
                     if (!second_word_q) begin
                        data1_q       <= pk_word;
                        data1_valid_q <= 1'b1;
                     end else begin
                        data2_q       <= pk_word;
                        data2_valid_q <= 1'b1;
                     end
                     if ((opcode_q == OP_ADD) && !second_word_q && !last_byte) begin
                        second_word_q <= 1'b1;
                     end else begin
                        second_word_q <= 1'b0;
                        top_byte_q    <= last_byte ? pk_fill : 2'd0;
                        state_q       <= ST_ISSUE;
                     end
                  end
               end
               ST_DROP: if (accept) begin
                  remaining_q <= remaining_q - LEN_W'(1);
                  if (last_byte) begin
                     done_q  <= 1'b1;
                     state_q <= ST_OPC;
                  end
               end
               ST_ISSUE: if (!alu_busy_i) state_q <= ST_SETTLE;
               ST_SETTLE: begin
                  if (remaining_q != '0) begin
                     state_q <= ST_COLLECT;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= ST_OPC;
                  end
               end
               default: state_q <= ST_OPC;
            endcase
         end
      end
   end

   assign opcode_o      = opcode_q;
   assign data1_o       = {1'b0, data1_q};
   assign data2_o       = {1'b0, data2_q};
   assign data1_valid_o = data1_valid_q;
   assign data2_valid_o = data2_valid_q;
   assign top_byte_o    = top_byte_q;
   assign pkt_done_o    = done_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_alu_packet_assembler.sv
// Directed self-checking bench for alu_packet_assembler; the timeout scenario is only
// exercised when ALU_ASM_TIMEOUT_EN is defined.
module tb_alu_packet_assembler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data_i = '0;
   logic        rx_valid_i = 1'b0;
   logic        rx_ready_o;
   logic        alu_busy_i = 1'b0;
   logic [7:0]  opcode_o;
   logic [32:0] data1_o;
   logic        data1_valid_o;
   logic [32:0] data2_o;
   logic        data2_valid_o;
   logic [1:0]  top_byte_o;
   logic        start_alu_o;
   logic        pkt_done_o;
   logic        err_o;

   int checks = 0;
   int failures = 0;

   int cycleCount = 0;
   int acceptCycle = 0;
   int startCycle = 0;
   int startCount = 0;
   int doneCount = 0;
   int errCount = 0;
   int baseStart, baseDone, baseErr;
   logic [32:0] capData1, capData2;
   logic        capV1, capV2;
   logic [1:0]  capTop;
   logic [7:0]  capOp;
   logic [7:0]  pkt[$];

   alu_packet_assembler #(
      .TIMEOUT_CYCLES(32'd50)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data_i     (rx_data_i),
      .rx_valid_i    (rx_valid_i),
      .rx_ready_o    (rx_ready_o),
      .alu_busy_i    (alu_busy_i),
      .opcode_o      (opcode_o),
      .data1_o       (data1_o),
      .data1_valid_o (data1_valid_o),
      .data2_o       (data2_o),
      .data2_valid_o (data2_valid_o),
      .top_byte_o    (top_byte_o),
      .start_alu_o   (start_alu_o),
      .pkt_done_o    (pkt_done_o),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   // Pulse monitor: samples mid-low-phase, clear of both clock edges and stimulus updates
   always @(negedge clk) begin
      #2;
      cycleCount++;
      if (start_alu_o) begin
         startCount++;
         startCycle = cycleCount;
         capData1   = data1_o;
         capData2   = data2_o;
         capV1      = data1_valid_o;
         capV2      = data2_valid_o;
         capTop     = top_byte_o;
         capOp      = opcode_o;
      end
      if (pkt_done_o) doneCount++;
      if (err_o) errCount++;
   end

   task automatic checkOutput(input string tag, input logic [95:0] observed,
                              input logic [95:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one byte and holds it until the DUT accepts it; returns on the following negedge
   task automatic applyStimulus(input logic [7:0] b);
      int n = 0;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      while (!rx_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("[TB] FAIL rxReadyWait observed=0 expected=1");
      end
      @(negedge clk);
      rx_valid_i  = 1'b0;
      acceptCycle = cycleCount;
   endtask

   task automatic sendPkt();
      foreach (pkt[i]) applyStimulus(pkt[i]);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      baseStart = startCount;
      baseDone  = doneCount;
      baseErr   = errCount;
   endtask

   function automatic logic [95:0] ctrlOuts();
      return {80'd0, rx_ready_o, data1_valid_o, data2_valid_o, top_byte_o,
              start_alu_o, pkt_done_o, err_o, opcode_o};
   endfunction

   initial begin
      // Power-on reset
      waitCycles(3);
      #2;
      checkOutput("resetCtrl", ctrlOuts(), 96'd0);
      checkOutput("resetData", {30'd0, data1_o, data2_o}, 96'd0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      checkOutput("readyAfterReset", 96'(rx_ready_o), 96'd1);
      @(negedge clk);

      // Add with two full words
      snap();
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
              8'h07, 8'h00, 8'h00, 8'h00};
      sendPkt();
      waitCycles(5);
      checkOutput("addStarts", 96'(startCount - baseStart), 96'd1);
      checkOutput("addLatency", 96'(startCycle - acceptCycle), 96'd1);
      checkOutput("addData1", 96'(capData1), 96'd5);
      checkOutput("addData2", 96'(capData2), 96'd7);
      checkOutput("addValids", {93'd0, capV1, capV2, 1'b0}, {93'd0, 3'b110});
      checkOutput("addTopOp", {86'd0, capTop, capOp}, {86'd0, 2'd0, 8'hAD});
      checkOutput("addDone", 96'(doneCount - baseDone), 96'd1);
      checkOutput("addNoErr", 96'(errCount - baseErr), 96'd0);

      // Echo with a 3-byte final word
      snap();
      pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      sendPkt();
      waitCycles(5);
      checkOutput("echoStarts", 96'(startCount - baseStart), 96'd1);
      checkOutput("echoData1", 96'(capData1), 96'h434241);
      checkOutput("echoValids", {94'd0, capV1, capV2}, {94'd0, 2'b10});
      checkOutput("echoTop", 96'(capTop), 96'd3);
      checkOutput("echoDone", 96'(doneCount - baseDone), 96'd1);
      checkOutput("echoHold", 96'(data1_o), 96'h434241);

      // ALU busy across the issue
      snap();
      alu_busy_i = 1'b1;
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00};
      sendPkt();
      begin
         int readyHigh = 0;
         repeat (10) begin
            if (rx_ready_o) readyHigh++;
            @(negedge clk);
         end
         checkOutput("busyReadyLow", 96'(readyHigh), 96'd0);
      end
      checkOutput("busyNoStart", 96'(startCount - baseStart), 96'd0);
      alu_busy_i = 1'b0;
      #2;
      checkOutput("busyStartFirst", 96'(start_alu_o), 96'd1);
      waitCycles(5);
      checkOutput("busyStartOnce", 96'(startCount - baseStart), 96'd1);
      checkOutput("busyData", {30'd0, capData1, capData2}, {30'd0, 33'd1, 33'd2});
      checkOutput("busyDone", 96'(doneCount - baseDone), 96'd1);

      // Unknown opcode: payload dropped
      snap();
      pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
      sendPkt();
      waitCycles(3);
      checkOutput("badOpErr", 96'(errCount - baseErr), 96'd1);
      checkOutput("badOpDone", 96'(doneCount - baseDone), 96'd1);
      checkOutput("badOpNoStart", 96'(startCount - baseStart), 96'd0);

      // Length shorter than header, then a fresh echo
      snap();
      pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
      sendPkt();
      waitCycles(3);
      checkOutput("shortLenErr", 96'(errCount - baseErr), 96'd1);
      checkOutput("shortLenNoDone", 96'(doneCount - baseDone), 96'd0);
      snap();
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
      sendPkt();
      waitCycles(5);
      checkOutput("afterShortStart", 96'(startCount - baseStart), 96'd1);
      checkOutput("afterShortData", {93'd0, capData1[7:0], capTop, capV2} >> 0,
                  {93'd0, 8'h99, 2'd1, 1'b0});

      // Header-only packet
      snap();
      pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
      sendPkt();
      waitCycles(3);
      checkOutput("emptyPkt", {64'd0, 32'(doneCount - baseDone)},
                  {64'd0, 32'd1});
      checkOutput("emptyNoErrStart", 96'((errCount - baseErr) + (startCount - baseStart)),
                  96'd0);

      // Oversized length is clamped: 1020 payload bytes dropped
      snap();
      pkt = '{8'h55, 8'h00, 8'h00, 8'h05};
      for (int i = 0; i < 1020; i++) pkt.push_back(8'(i));
      sendPkt();
      waitCycles(3);
      checkOutput("clampErr", 96'(errCount - baseErr), 96'd1);
      checkOutput("clampDone", 96'(doneCount - baseDone), 96'd1);

      // Reset in the middle of an add packet
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00};
      sendPkt();
      rst = 1'b1;
      waitCycles(2);
      #2;
      checkOutput("midResetCtrl", ctrlOuts(), 96'd0);
      checkOutput("midResetData", {30'd0, data1_o, data2_o}, 96'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      snap();
      pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
      sendPkt();
      waitCycles(5);
      checkOutput("postResetStart", 96'(startCount - baseStart), 96'd1);
      checkOutput("postResetData", 96'(capData1), 96'h2211);
      checkOutput("postResetTopOp", {86'd0, capTop, capOp}, {86'd0, 2'd2, 8'hEC});

`ifdef ALU_ASM_TIMEOUT_EN
      // Stall mid-payload until the idle timeout fires
      snap();
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05};
      sendPkt();
      waitCycles(60);
      checkOutput("timeoutErr", 96'(errCount - baseErr), 96'd1);
      checkOutput("timeoutNoStart", 96'(startCount - baseStart), 96'd0);
      snap();
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h3C};
      sendPkt();
      waitCycles(5);
      checkOutput("afterTimeoutData", {62'd0, capData1, capV1},
                  {62'd0, 33'h3C, 1'b1});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL globalTimeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule
